// File: rtl/trdb_packet_decoder.sv
// ---------------------------------------------------------------------------
// trdb_packet_decoder
//
// Decodes a serial stream of 32-bit trace words into packets. Each packet
// starts with a header word that carries the payload length, format,
// subformat and branch count, followed by LEN payload words. Headers whose
// LEN does not match the format are reported on err_o and their payload
// words are skipped.
//
// Header word layout:
//   [3:0]   LEN        payload words that follow the header
//   [5:4]   format     0 BRANCH_FULL, 1 BRANCH_DIFF, 2 ADDR_ONLY, 3 SYNC
//   [7:6]   subformat  0 START, 1 EXCEPTION, 2 CONTEXT, 3 UNDEF
//   [12:8]  branches
//   [31:13] ignored
//
// Ports:
//   clk_i             clock, all state updates on the rising edge
//   rst_i             synchronous active-high reset
//   word_i            incoming stream word
//   word_valid_i      word_i valid
//   word_ready_o      decoder can take word_i (low while a packet waits)
//   flush_i           abort any partially received or pending packet
//   pkt_valid_o       decoded packet available
//   pkt_ready_i       consumer takes the packet
//   pkt_format_o      packet format
//   pkt_subformat_o   packet subformat
//   pkt_branches_o    branch count from the header
//   pkt_branch_map_o  branch map (BRANCH_FULL only, else 0)
//   pkt_addr_o        address payload
//   pkt_cause_o       exception cause (SYNC/EXCEPTION only, else 0)
//   err_o             one-cycle pulse per malformed header
//   pkt_cnt_o         saturating count of packets handed off
//   err_cnt_o         saturating count of malformed headers
// ---------------------------------------------------------------------------
module trdb_packet_decoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      word_i,
    input  logic             word_valid_i,
    output logic             word_ready_o,
    input  logic             flush_i,
    output logic             pkt_valid_o,
    input  logic             pkt_ready_i,
    output logic [1:0]       pkt_format_o,
    output logic [1:0]       pkt_subformat_o,
    output logic [4:0]       pkt_branches_o,
    output logic [31:0]      pkt_branch_map_o,
    output logic [31:0]      pkt_addr_o,
    output logic [31:0]      pkt_cause_o,
    output logic             err_o,
    output logic [CNT_W-1:0] pkt_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int unsigned LEN_W  = 4;
    localparam int unsigned FMT_W  = 2;
    localparam int unsigned BR_W   = 5;
    localparam int unsigned WORD_W = 32;

    localparam logic [FMT_W-1:0] F_BRANCH_FULL = 2'd0;
    localparam logic [FMT_W-1:0] F_ADDR_ONLY   = 2'd2;
    localparam logic [FMT_W-1:0] F_SYNC        = 2'd3;
    localparam logic [FMT_W-1:0] SF_EXCEPTION  = 2'd1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_HDR     = 2'd0,
        S_PAYLOAD = 2'd1,
        S_SKIP    = 2'd2,
        S_EMIT    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic              accept;
    logic              emit;
    logic              word_fire;
    logic              pkt_fire;

    logic [LEN_W-1:0]  hdr_len;
    logic [FMT_W-1:0]  hdr_fmt;
    logic [FMT_W-1:0]  hdr_sf;
    logic [BR_W-1:0]   hdr_br;
    logic [LEN_W-1:0]  hdr_exp_len;
    logic              hdr_supported;
    logic              hdr_ok;

    logic [LEN_W-1:0]  cnt;
    logic [FMT_W-1:0]  fmt_q;
    logic [FMT_W-1:0]  sf_q;
    logic [BR_W-1:0]   br_q;
    logic [WORD_W-1:0] map_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] cause_q;
    logic              err_q;
    logic [CNT_W-1:0]  pkt_cnt_q;
    logic [CNT_W-1:0]  err_cnt_q;

    logic              two_word;
    logic              exc_sync;
    logic              store_map;
    logic              store_addr;
    logic              store_cause;

    // Header field extraction
    assign hdr_len = word_i[3:0];
    assign hdr_fmt = word_i[5:4];
    assign hdr_sf  = word_i[7:6];
    assign hdr_br  = word_i[12:8];

    // Expected payload length per format; BRANCH_DIFF is not supported
    always_comb begin
        hdr_exp_len   = '0;
        hdr_supported = 1'b0;
        case (hdr_fmt)
            F_BRANCH_FULL: begin
                hdr_exp_len   = 4'd2;
                hdr_supported = 1'b1;
            end
            F_ADDR_ONLY: begin
                hdr_exp_len   = 4'd1;
                hdr_supported = 1'b1;
            end
            F_SYNC: begin
                hdr_exp_len   = (hdr_sf == SF_EXCEPTION) ? 4'd2 : 4'd1;
                hdr_supported = 1'b1;
            end
            default: begin
                hdr_exp_len   = '0;
                hdr_supported = 1'b0;
            end
        endcase
    end

    assign hdr_ok = hdr_supported && (hdr_len == hdr_exp_len);

    assign word_fire = word_valid_i && accept;
    assign pkt_fire  = emit && pkt_ready_i;

    // Payload slot decode: cnt counts down, so the first word of a
    // two-word packet arrives with cnt == 2 and the last with cnt == 1
    assign exc_sync    = (fmt_q == F_SYNC) && (sf_q == SF_EXCEPTION);
    assign two_word    = (fmt_q == F_BRANCH_FULL) || exc_sync;
    assign store_map   = (fmt_q == F_BRANCH_FULL) && (cnt == 4'd2);
    assign store_cause = exc_sync && (cnt == 4'd1);
    assign store_addr  = ((fmt_q == F_BRANCH_FULL) && (cnt == 4'd1)) ||
                         (exc_sync && (cnt == 4'd2)) ||
                         (!two_word && (cnt == 4'd1));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_HDR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush overrides every handshake
    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = S_HDR;
        end else begin
            case (state)
                S_HDR: begin
                    if (word_fire) begin
                        if (hdr_ok) begin
                            state_next = S_PAYLOAD;
                        end else if (hdr_len != '0) begin
                            state_next = S_SKIP;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (word_fire && (cnt == 4'd1)) begin
                        state_next = S_EMIT;
                    end
                end
                S_SKIP: begin
                    if (word_fire && (cnt == 4'd1)) begin
                        state_next = S_HDR;
                    end
                end
                S_EMIT: begin
                    if (pkt_fire) begin
                        state_next = S_HDR;
                    end
                end
                default: state_next = S_HDR;
            endcase
        end
    end

    // State-decoded handshake outputs
    always_comb begin
        accept = 1'b0;
        emit   = 1'b0;
        case (state)
            S_HDR, S_PAYLOAD, S_SKIP: accept = 1'b1;
            S_EMIT:                   emit   = 1'b1;
            default: begin
                accept = 1'b0;
                emit   = 1'b0;
            end
        endcase
    end

    // Length counter, shadow fields, error pulse and statistics
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt       <= '0;
            fmt_q     <= '0;
            sf_q      <= '0;
            br_q      <= '0;
            map_q     <= '0;
            addr_q    <= '0;
            cause_q   <= '0;
            err_q     <= 1'b0;
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            err_q <= 1'b0;
            if (flush_i) begin
                cnt <= '0;
            end else begin
                case (state)
                    S_HDR: begin
                        if (word_fire) begin
                            fmt_q   <= hdr_fmt;
                            sf_q    <= hdr_sf;
                            br_q    <= hdr_br;
                            map_q   <= '0;
                            addr_q  <= '0;
                            cause_q <= '0;
                            cnt     <= hdr_len;
                            if (!hdr_ok) begin
                                err_q <= 1'b1;
                                if (err_cnt_q != CNT_MAX) begin
                                    err_cnt_q <= err_cnt_q + CNT_W'(1);
                                end
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (word_fire) begin
                            if (store_map) begin
                                map_q <= word_i;
                            end
                            if (store_addr) begin
                                addr_q <= word_i;
                            end
                            if (store_cause) begin
                                cause_q <= word_i;
                            end
                            cnt <= cnt - 4'd1;
                        end
                    end
                    S_SKIP: begin
                        if (word_fire) begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    S_EMIT: begin
                        if (pkt_fire && (pkt_cnt_q != CNT_MAX)) begin
                            pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
                        end
                    end
                    default: cnt <= '0;
                endcase
            end
        end
    end

    assign word_ready_o     = accept;
    assign pkt_valid_o      = emit;
    assign pkt_format_o     = fmt_q;
    assign pkt_subformat_o  = sf_q;
    assign pkt_branches_o   = br_q;
    assign pkt_branch_map_o = map_q;
    assign pkt_addr_o       = addr_q;
    assign pkt_cause_o      = cause_q;
    assign err_o            = err_q;
    assign pkt_cnt_o        = pkt_cnt_q;
    assign err_cnt_o        = err_cnt_q;

endmodule

// File: tb/tb_trdb_packet_decoder.sv
// ---------------------------------------------------------------------------
// tb_trdb_packet_decoder
//
// Drives directed and random word streams into trdb_packet_decoder. A
// transaction-level model turns each generated header/payload group into
// an expected event (packet or error) and the per-cycle checker matches
// DUT events, counters and handshake behaviour against it.
// ---------------------------------------------------------------------------
module tb_trdb_packet_decoder;

    localparam int unsigned TB_CNT_W = 4;
    localparam logic [TB_CNT_W-1:0] TB_CNT_MAX = {TB_CNT_W{1'b1}};

    logic                clk = 1'b0;
    logic                rst_i;
    logic [31:0]         word_i;
    logic                word_valid_i;
    logic                word_ready_o;
    logic                flush_i;
    logic                pkt_valid_o;
    logic                pkt_ready_i;
    logic [1:0]          pkt_format_o;
    logic [1:0]          pkt_subformat_o;
    logic [4:0]          pkt_branches_o;
    logic [31:0]         pkt_branch_map_o;
    logic [31:0]         pkt_addr_o;
    logic [31:0]         pkt_cause_o;
    logic                err_o;
    logic [TB_CNT_W-1:0] pkt_cnt_o;
    logic [TB_CNT_W-1:0] err_cnt_o;

    trdb_packet_decoder #(.CNT_W(TB_CNT_W)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .word_i           (word_i),
        .word_valid_i     (word_valid_i),
        .word_ready_o     (word_ready_o),
        .flush_i          (flush_i),
        .pkt_valid_o      (pkt_valid_o),
        .pkt_ready_i      (pkt_ready_i),
        .pkt_format_o     (pkt_format_o),
        .pkt_subformat_o  (pkt_subformat_o),
        .pkt_branches_o   (pkt_branches_o),
        .pkt_branch_map_o (pkt_branch_map_o),
        .pkt_addr_o       (pkt_addr_o),
        .pkt_cause_o      (pkt_cause_o),
        .err_o            (err_o),
        .pkt_cnt_o        (pkt_cnt_o),
        .err_cnt_o        (err_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_err;
        logic [1:0]  fmt;
        logic [1:0]  sf;
        logic [4:0]  br;
        logic [31:0] map;
        logic [31:0] addr;
        logic [31:0] cause;
    } ev_t;

    logic [31:0] word_q[$];
    bit          last_q[$];
    ev_t         ev_q[$];

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    logic [TB_CNT_W-1:0] m_pkt = '0;
    logic [TB_CNT_W-1:0] m_err = '0;

    bit          exp_valid = 1'b0;
    bit          hold      = 1'b0;
    logic [127:0] held_bus = '0;
    int          ready_mode = 0;   // 0 always, 1 random, 2 low for 5 valid cycles, 3 never
    bit          gaps       = 1'b0;
    bit          rst_req    = 1'b0;
    bit          flush_req  = 1'b0;
    int          valid_run  = 0;
    int          last_run   = 0;
    ev_t         last_pkt   = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Payload length the format rules demand; -1 marks an unsupported format
    function automatic int exp_len(input logic [1:0] fmt, input logic [1:0] sf);
        case (fmt)
            2'd0:    return 2;
            2'd1:    return -1;
            2'd2:    return 1;
            default: return (sf == 2'd1) ? 2 : 1;
        endcase
    endfunction

    function automatic logic [127:0] dut_bus();
        return 128'({pkt_format_o, pkt_subformat_o, pkt_branches_o,
                     pkt_branch_map_o, pkt_addr_o, pkt_cause_o});
    endfunction

    function automatic logic [127:0] ev_bus(input ev_t e);
        return 128'({e.fmt, e.sf, e.br, e.map, e.addr, e.cause});
    endfunction

    task automatic push_raw(input logic [31:0] w, input bit last);
        word_q.push_back(w);
        last_q.push_back(last);
    endtask

    // Queue a header plus LEN payload words and record the expected event
    task automatic push_pkt(input logic [31:0] hdr, input logic [31:0] w0,
                            input logic [31:0] w1, input bit expect_ev);
        int          len;
        int          el;
        ev_t         e;
        logic [31:0] w;
        len = int'(hdr[3:0]);
        el  = exp_len(hdr[5:4], hdr[7:6]);
        push_raw(hdr, 1'b0);
        for (int k = 0; k < len; k++) begin
            w = (k == 0) ? w0 : (k == 1) ? w1 : $urandom;
            push_raw(w, (el == len) && (k == len - 1));
        end
        e = '0;
        if (el == len) begin
            e.fmt = hdr[5:4];
            e.sf  = hdr[7:6];
            e.br  = hdr[12:8];
            if (hdr[5:4] == 2'd0) begin
                e.map  = w0;
                e.addr = w1;
            end else if (hdr[5:4] == 2'd3 && hdr[7:6] == 2'd1) begin
                e.addr  = w0;
                e.cause = w1;
            end else begin
                e.addr = w0;
            end
        end else begin
            e.is_err = 1'b1;
        end
        if (expect_ev) ev_q.push_back(e);
    endtask

    // One cycle: check outputs at the falling edge, then drive the next inputs
    task automatic step();
        bit acc;
        bit ok_ev;
        @(negedge clk);
        if (exp_valid) chk("valid_latency", 128'(pkt_valid_o), 128'(1));
        exp_valid = 1'b0;
        chk("word_ready", 128'(word_ready_o), 128'(!pkt_valid_o));
        if (hold) chk("pkt_stable", dut_bus(), held_bus);
        if (pkt_valid_o) valid_run++;
        if (err_o) begin
            ok_ev = (ev_q.size() > 0) && ev_q[0].is_err;
            chk("err_event", 128'(ok_ev), 128'(1));
            if (ok_ev) void'(ev_q.pop_front());
            if (m_err != TB_CNT_MAX) m_err++;
        end
        chk("err_cnt", 128'(err_cnt_o), 128'(m_err));
        chk("pkt_cnt", 128'(pkt_cnt_o), 128'(m_pkt));

        rst_i   = rst_req;
        flush_i = flush_req;
        if (rst_req || flush_req) begin
            word_valid_i = 1'b0;
            word_i       = $urandom;
            pkt_ready_i  = 1'b0;
        end else begin
            if (word_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                word_valid_i = 1'b1;
                word_i       = word_q[0];
            end else begin
                word_valid_i = 1'b0;
                word_i       = $urandom;
            end
            case (ready_mode)
                0:       pkt_ready_i = 1'b1;
                1:       pkt_ready_i = 1'($urandom_range(0, 1));
                2:       pkt_ready_i = pkt_valid_o && (valid_run >= 6);
                default: pkt_ready_i = 1'b0;
            endcase
        end
        if (rst_req) begin
            m_pkt = '0;
            m_err = '0;
            ev_q.delete();
        end

        acc = word_valid_i && word_ready_o;
        if (acc) begin
            exp_valid = last_q.pop_front();
            void'(word_q.pop_front());
        end
        if (pkt_valid_o && pkt_ready_i) begin
            ok_ev = (ev_q.size() > 0) && !ev_q[0].is_err;
            chk("pkt_event", 128'(ok_ev), 128'(1));
            if (ok_ev) begin
                chk("pkt_fields", dut_bus(), ev_bus(ev_q[0]));
                void'(ev_q.pop_front());
            end
            last_pkt = '{1'b0, pkt_format_o, pkt_subformat_o, pkt_branches_o,
                         pkt_branch_map_o, pkt_addr_o, pkt_cause_o};
            last_run  = valid_run;
            valid_run = 0;
            if (m_pkt != TB_CNT_MAX) m_pkt++;
        end
        if (!pkt_valid_o || rst_req || flush_req) valid_run = 0;
        hold     = pkt_valid_o && !pkt_ready_i && !rst_req && !flush_req;
        held_bus = dut_bus();
    endtask

    task automatic run(input int max_cyc, input bit stop_on_valid);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            step();
            if (stop_on_valid)
                done = (word_q.size() == 0) && pkt_valid_o;
            else
                done = (word_q.size() == 0) && (ev_q.size() == 0) && !pkt_valid_o;
        end
        chk("run_done", 128'(done), 128'(1));
    endtask

    initial begin
        logic [1:0] fmt;
        logic [1:0] sf;
        logic [3:0] len;
        int         el;

        rst_i        = 1'b1;
        flush_i      = 1'b0;
        word_valid_i = 1'b0;
        word_i       = '0;
        pkt_ready_i  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;

        chk("rst_pkt_valid", 128'(pkt_valid_o), 128'(0));
        chk("rst_err", 128'(err_o), 128'(0));
        chk("rst_word_ready", 128'(word_ready_o), 128'(1));
        chk("rst_fields", dut_bus(), 128'(0));
        chk("rst_pkt_cnt", 128'(pkt_cnt_o), 128'(0));
        chk("rst_err_cnt", 128'(err_cnt_o), 128'(0));

        // Single ADDR_ONLY packet
        push_pkt(32'h0000_0021, 32'h8000_1000, 32'h0, 1'b1);
        run(100, 1'b0);
        chk("d1_addr", 128'(last_pkt.addr), 128'(32'h8000_1000));
        chk("d1_fmt", 128'(last_pkt.fmt), 128'(2));
        chk("d1_map_cause", 128'({last_pkt.map, last_pkt.cause}), 128'(0));
        chk("d1_pkt_cnt", 128'(pkt_cnt_o), 128'(1));

        // BRANCH_FULL with consumer back-pressure
        ready_mode = 2;
        push_pkt(32'h0000_1F02, 32'hAAAA_5555, 32'h1C00_0080, 1'b1);
        run(100, 1'b0);
        ready_mode = 0;
        chk("d2_hold_cycles", 128'(last_run), 128'(6));
        chk("d2_map", 128'(last_pkt.map), 128'(32'hAAAA_5555));
        chk("d2_addr", 128'(last_pkt.addr), 128'(32'h1C00_0080));
        chk("d2_branches", 128'(last_pkt.br), 128'(31));
        chk("d2_pkt_cnt", 128'(pkt_cnt_o), 128'(2));

        // SYNC/EXCEPTION with wrong LEN, words skipped, then a good packet
        push_pkt(32'h0000_0073, 32'h1111_1111, 32'h2222_2222, 1'b1);
        push_pkt(32'h0000_0021, 32'h1234_5678, 32'h0, 1'b1);
        run(100, 1'b0);
        chk("d3_err_cnt", 128'(err_cnt_o), 128'(1));
        chk("d3_addr", 128'(last_pkt.addr), 128'(32'h1234_5678));
        chk("d3_pkt_cnt", 128'(pkt_cnt_o), 128'(3));

        // BRANCH_DIFF with LEN 0: the next word is a header again
        push_pkt(32'h0000_0010, 32'h0, 32'h0, 1'b1);
        push_pkt(32'h0000_0021, 32'h0000_0044, 32'h0, 1'b1);
        run(100, 1'b0);
        chk("d4_err_cnt", 128'(err_cnt_o), 128'(2));
        chk("d4_addr", 128'(last_pkt.addr), 128'(32'h0000_0044));

        // Flush after the first BRANCH_FULL payload word
        push_raw(32'h0000_0102, 1'b0);
        push_raw(32'hCAFE_0001, 1'b0);
        run(100, 1'b0);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        chk("d5_pkt_cnt", 128'(pkt_cnt_o), 128'(4));
        push_pkt(32'h0000_0031, 32'h0000_0ABC, 32'h0, 1'b1);
        run(100, 1'b0);
        chk("d5_fmt_sf", 128'({last_pkt.fmt, last_pkt.sf}), 128'(4'b1100));
        chk("d5_addr", 128'(last_pkt.addr), 128'(32'h0000_0ABC));
        chk("d5_pkt_cnt", 128'(pkt_cnt_o), 128'(5));

        // Flush while a packet waits in EMIT: dropped, not counted
        ready_mode = 3;
        push_pkt(32'h0000_0021, 32'hDEAD_BEEF, 32'h0, 1'b0);
        run(100, 1'b1);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        chk("d6_valid", 128'(pkt_valid_o), 128'(0));
        chk("d6_pkt_cnt", 128'(pkt_cnt_o), 128'(5));

        // Reset while a packet waits in EMIT
        push_pkt(32'h0000_0021, 32'h5555_0000, 32'h0, 1'b0);
        run(100, 1'b1);
        chk("d7_valid_before", 128'(pkt_valid_o), 128'(1));
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        chk("d7_valid", 128'(pkt_valid_o), 128'(0));
        chk("d7_counts", 128'({pkt_cnt_o, err_cnt_o}), 128'(0));
        chk("d7_ready", 128'(word_ready_o), 128'(1));
        ready_mode = 0;
        push_pkt(32'h0000_0021, 32'h0BAD_F00D, 32'h0, 1'b1);
        run(100, 1'b0);
        chk("d7_restart_addr", 128'(last_pkt.addr), 128'(32'h0BAD_F00D));
        chk("d7_restart_cnt", 128'(pkt_cnt_o), 128'(1));

        // Random traffic, long enough to saturate both counters
        ready_mode = 1;
        gaps       = 1'b1;
        for (int p = 0; p < 90; p++) begin
            fmt = 2'($urandom_range(0, 3));
            sf  = 2'($urandom_range(0, 3));
            el  = exp_len(fmt, sf);
            if ($urandom_range(0, 9) < 6 && el > 0)
                len = 4'(el);
            else
                len = 4'($urandom_range(0, 15));
            push_pkt({19'($urandom), 5'($urandom), sf, fmt, len},
                     $urandom, $urandom, 1'b1);
        end
        run(20000, 1'b0);
        chk("rand_pkt_sat", 128'(pkt_cnt_o), 128'(TB_CNT_MAX));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/trdb_packet_decoder.md
TRDB_PACKET_DECODER -- requirements
Module: trdb_packet_decoder

Interface
REQ-001 Parameter: CNT_W, 16, width of the packet and error counters.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 word_i  in  32  serial packet word stream.
REQ-005 word_valid_i  in  1  word_i valid.
REQ-006 word_ready_o  out  1  decoder accepts word_i; transfer when valid and ready are both high.
REQ-007 flush_i  in  1  synchronous abort of any partially received packet.
REQ-008 pkt_valid_o  out  1  decoded packet available.
REQ-009 pkt_ready_i  in  1  consumer accepts packet; transfer when valid and ready are both high.
REQ-010 pkt_format_o  out  2  trdb_format_t: F_BRANCH_FULL=0, F_BRANCH_DIFF=1, F_ADDR_ONLY=2, F_SYNC=3.
REQ-011 pkt_subformat_o  out  2  trdb_subformat_t: SF_START=0, SF_EXCEPTION=1, SF_CONTEXT=2, SF_UNDEF=3.
REQ-012 pkt_branches_o  out  5  branch count from header.
REQ-013 pkt_branch_map_o  out  32  branch map (F_BRANCH_FULL only, else 0).
REQ-014 pkt_addr_o  out  32  address payload.
REQ-015 pkt_cause_o  out  32  exception cause (F_SYNC/SF_EXCEPTION only, else 0).
REQ-016 err_o  out  1  one-cycle pulse on malformed header.
REQ-017 pkt_cnt_o  out  CNT_W  saturating count of packets handed off.
REQ-018 err_cnt_o  out  CNT_W  saturating count of err_o pulses.

Function
REQ-019 Header word: [3:0] LEN (payload words following), [5:4] format, [7:6] subformat, [12:8] branches, [31:13] ignored.
REQ-020 Expected LEN: F_BRANCH_FULL 2 (map, then addr); F_ADDR_ONLY 1 (addr); F_SYNC with SF_EXCEPTION 2 (addr, then cause); F_SYNC other subformats 1 (addr); F_BRANCH_DIFF unsupported.
REQ-021 FSM states: HDR, PAYLOAD, SKIP, EMIT; reset state HDR.
REQ-022 HDR: on accepted word, latch format/subformat/branches, clear map/addr/cause shadow regs; LEN equal to expected -> PAYLOAD; otherwise pulse err_o next cycle and go to SKIP if LEN>0, stay in HDR if LEN=0.
REQ-023 PAYLOAD: 4-bit down-counter loaded with LEN; each accepted word stored into the field for its position per REQ-020; on last word -> EMIT.
REQ-024 SKIP: accept and discard LEN words, then -> HDR; no packet emitted.
REQ-025 word_ready_o high in HDR, PAYLOAD, SKIP; low in EMIT.
REQ-026 EMIT: pkt_valid_o high; all pkt_* outputs registered and stable until handshake; on handshake -> HDR, increment pkt_cnt_o.
REQ-027 Latency: pkt_valid_o asserts the cycle after the last payload word is accepted; a header may be accepted the cycle after the packet handshake.
REQ-028 word_valid_i low in any state: no state change, counter held.
REQ-029 flush_i high: next state HDR, counter cleared, pkt_valid_o low next cycle (pending EMIT packet dropped, not counted); flush wins over a simultaneous word or packet handshake; counters not cleared.
REQ-030 Counters saturate at all ones; no wrap.
REQ-031 err_o and err_cnt_o increment in the same cycle; one error per malformed header.

Reset
REQ-032 rst_i high at a clock edge: state HDR, pkt_valid_o=0, err_o=0, word_ready_o=1 after reset, all pkt_* fields 0, both counters 0.
REQ-033 rst_i dominates flush_i and all handshakes; reset mid-packet discards the partial packet.

Verification
REQ-034 Words 0x0000_0021, 0x8000_1000 with pkt_ready_i=1 -> one packet F_ADDR_ONLY, addr 0x8000_1000, map 0, cause 0, pkt_cnt_o=1.
REQ-035 Header 0x0000_1F02 (F_BRANCH_FULL, 31 branches, LEN 2), map 0xAAAA_5555, addr 0x1C00_0080, pkt_ready_i held low 5 cycles -> outputs stable, word_ready_o low, then single handoff.
REQ-036 Header 0x0000_0073 (F_SYNC/SF_EXCEPTION, LEN 3) + 3 words -> err_o one pulse, err_cnt_o=1, 3 words skipped, next valid header decoded correctly.
REQ-037 Header 0x0000_0010 (F_BRANCH_DIFF, LEN 0) -> err_o pulse, remains HDR, next word treated as header.
REQ-038 flush_i asserted after first payload word of F_BRANCH_FULL -> no packet, pkt_cnt_o unchanged, following F_SYNC/SF_START packet (0x0000_0031, addr) decoded.
REQ-039 rst_i pulsed while in EMIT -> pkt_valid_o 0 next cycle, counters 0, stream restarts in HDR.
